// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues word addresses, pairs memory data with PCs.
// Define FETCH_CNT_EN to build the delivered-instruction counter on fetch_count.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_09F0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        cs_p,
    input  logic [31:0] imem_data,
    output logic [31:0] addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fault_q, fault_d;
`ifdef FETCH_CNT_EN
    logic [31:0] count_q, count_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        fault_d    = fault_q;
`ifdef FETCH_CNT_EN
        count_d    = count_q;
`endif
        unique case (state_q)
            StRun: begin
                if (br_valid) begin
                    // Redirect squashes both the in-flight fetch and the current output.
                    addr_d     = br_target;
                    pending_d  = 1'b0;
                    if_valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; memory output stays stable meanwhile.
                end else if (!cs_p) begin
                    state_d    = StFault;
                    fault_d    = 1'b1;
                    pending_d  = 1'b0;
                    if_valid_d = 1'b0;
                end else begin
                    addr_d     = addr_q + PC_STEP;
                    pc_d       = addr_q;
                    pending_d  = 1'b1;
                    if_valid_d = pending_q;
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
`ifdef FETCH_CNT_EN
                    if (pending_q) begin
                        count_d = count_q + 32'd1;
                    end
`endif
                end
            end
            StFault: begin
                // Terminal until reset.
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            addr_q     <= RESET_PC;
            pc_q       <= 32'h0;
            pending_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            fault_q    <= fault_d;
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'h0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

    assign addr     = addr_q;
    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand sequences, and random traffic against a model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_09F0;
    localparam logic [31:0] WIN_LO  = 32'h0000_09F0;
    localparam logic [31:0] WIN_HI  = 32'h0000_1A13;
    localparam logic [31:0] MEM_OFS = 32'h0000_A000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        cs_p;
    logic [31:0] imem_data;
    logic [31:0] addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .cs_p       (cs_p),
        .imem_data  (imem_data),
        .addr       (addr),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .fault      (fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Environment: address decoder window and a synchronous memory that holds its output on stall.
    assign cs_p = (addr >= WIN_LO) && (addr <= WIN_HI);
    always @(posedge clk) if (!stall) imem_data <= addr + MEM_OFS;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= WIN_LO) && (a <= WIN_HI);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an address register, one in-flight slot, and the delivered output.
    logic [31:0] m_addr = RST_PC;
    logic        m_fault = 1'b0;
    logic        m_fly = 1'b0;
    logic [31:0] m_fly_pc = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_count = 32'h0;

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [31:0] t);
        if (r) begin
            m_addr = RST_PC; m_fault = 1'b0; m_fly = 1'b0; m_valid = 1'b0; m_pc = 32'h0;
            m_count = 32'h0;
        end else if (m_fault) begin
        end else if (b) begin
            m_addr = t; m_fly = 1'b0; m_valid = 1'b0;
        end else if (s) begin
        end else if (!in_window(m_addr)) begin
            m_fault = 1'b1; m_fly = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = m_fly;
            if (m_fly) begin
                m_pc = m_fly_pc;
                m_count = m_count + 32'd1;
            end
            m_fly = 1'b1;
            m_fly_pc = m_addr;
            m_addr = m_addr + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic [31:0] exp_cnt;
        rst = r; stall = s; br_valid = b; br_target = t;
        model_edge(r, s, b, t);
        @(posedge clk);
        #1;
`ifdef FETCH_CNT_EN
        exp_cnt = m_count;
`else
        exp_cnt = 32'h0;
`endif
        check("m_addr", addr, m_addr);
        check("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        check("m_fault", {31'b0, fault}, {31'b0, m_fault});
        check("m_fetch_count", fetch_count, exp_cnt);
        if (m_valid) begin
            check("m_if_pc", if_pc, m_pc);
            check("m_if_instr", if_instr, m_pc + MEM_OFS);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic        chk_data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                                input logic [31:0] ei, input logic ef, input logic cd);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.e_addr = ea; v.e_valid = ev;
        v.e_pc = ep; v.e_instr = ei; v.e_fault = ef; v.chk_data = cd;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        vecs[0]  = mk(1, 0, 0, 0,            32'h09F0, 0, 32'h0,    32'h0,    0, 1);
        vecs[1]  = mk(0, 0, 0, 0,            32'h09F1, 0, 0,        0,        0, 0);
        vecs[2]  = mk(0, 0, 0, 0,            32'h09F2, 1, 32'h09F0, 32'hA9F0, 0, 1);
        vecs[3]  = mk(0, 1, 1, 32'h1000,     32'h1000, 0, 0,        0,        0, 0);
        vecs[4]  = mk(0, 0, 0, 0,            32'h1001, 0, 0,        0,        0, 0);
        vecs[5]  = mk(0, 0, 0, 0,            32'h1002, 1, 32'h1000, 32'hB000, 0, 1);
        vecs[6]  = mk(0, 0, 1, 32'h1A13,     32'h1A13, 0, 0,        0,        0, 0);
        vecs[7]  = mk(0, 0, 0, 0,            32'h1A14, 0, 0,        0,        0, 0);
        vecs[8]  = mk(0, 0, 0, 0,            32'h1A14, 0, 0,        0,        1, 0);
        vecs[9]  = mk(0, 0, 1, 32'h0000,     32'h1A14, 0, 0,        0,        1, 0);
        vecs[10] = mk(0, 1, 0, 0,            32'h1A14, 0, 0,        0,        1, 0);
        vecs[11] = mk(1, 0, 0, 0,            32'h09F0, 0, 32'h0,    32'h0,    0, 1);
        vecs[12] = mk(0, 0, 1, 32'h08F0,     32'h08F0, 0, 0,        0,        0, 0);
        vecs[13] = mk(0, 0, 0, 0,            32'h08F0, 0, 0,        0,        1, 0);
        vecs[14] = mk(1, 0, 0, 0,            32'h09F0, 0, 32'h0,    32'h0,    0, 1);
        vecs[15] = mk(0, 0, 0, 0,            32'h09F1, 0, 0,        0,        0, 0);
        vecs[16] = mk(0, 0, 0, 0,            32'h09F2, 1, 32'h09F0, 32'hA9F0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall;
            br_valid = vecs[i].br; br_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
            check($sformatf("vec%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].e_fault});
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_if_instr", i), if_instr, vecs[i].e_instr);
            end
        end

        // Stall for three cycles once the PC reaches 0x0A00.
        step(1, 0, 0, 0);
        for (int n = 0; n < 64 && m_addr != 32'h0A00; n++) step(0, 0, 0, 0);
        check("reach_0a00", addr, 32'h0A00);
        for (int n = 0; n < 3; n++) begin
            step(0, 1, 0, 0);
            check("stall_addr_hold", addr, 32'h0A00);
        end
        step(0, 0, 0, 0);
        check("resume_addr", addr, 32'h0A01);
        step(0, 0, 0, 0);

        // Five deliveries after reset.
        step(1, 0, 0, 0);
        for (int n = 0; n < 6; n++) step(0, 0, 0, 0);
`ifdef FETCH_CNT_EN
        check("count_five", fetch_count, 32'd5);
`else
        check("count_tied_zero", fetch_count, 32'd0);
`endif

        // Random traffic.
        step(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       t = 32'h08F0;
                    1:       t = WIN_HI + 32'd1;
                    default: t = 32'hFFFF_FFFF;
                endcase
            end else begin
                t = WIN_LO + $urandom_range(0, 32'h1023);
            end
            step(r, s, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
